mips_multicycle_ctrl: RTL and testbench

Multicycle MIPS main control FSM: the producer side of the ALU's 4-bit `ctl` interface. It sequences each instruction through fetch, decode, execute, memory and write-back states. In each state it drives the ALU operation code, the datapath mux selects and the write enables. It sits between the instruction register (opcode/funct fields) and the shared ALU, register file, PC and memory port.

---
 rtl/mips_multicycle_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for a multicycle MIPS datapath. It steps each instruction through
// fetch, decode, execute, memory and write-back, and drives the ALU op, the mux selects and the write enables.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       alu_zero,
    output logic [3:0] alu_ctl,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       imm_zext,
    output logic [1:0] pc_source,
    output logic       pc_en,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       iord,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEM_ADDR = 4'd2;
    localparam logic [3:0] S_MEM_RD   = 4'd3;
    localparam logic [3:0] S_MEM_WB   = 4'd4;
    localparam logic [3:0] S_MEM_WR   = 4'd5;
    localparam logic [3:0] S_R_EXEC   = 4'd6;
    localparam logic [3:0] S_R_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH   = 4'd8;
    localparam logic [3:0] S_JUMP     = 4'd9;
    localparam logic [3:0] S_I_EXEC   = 4'd10;
    localparam logic [3:0] S_I_WB     = 4'd11;
    localparam logic [3:0] S_TRAP     = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    localparam logic [3:0] ALU_AND = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_NOR = 4'd12;

    logic [3:0] state_q;
    logic [3:0] state_d;
    logic       funct_legal;
    logic [3:0] r_alu_ctl;

    // NOTE: state uses non-blocking assignment with the synchronous reset inside the clocked block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        funct_legal = 1'b1;
        r_alu_ctl   = ALU_ADD;
        case (funct)
            F_ADD:   r_alu_ctl = ALU_ADD;
            F_SUB:   r_alu_ctl = ALU_SUB;
            F_AND:   r_alu_ctl = ALU_AND;
            F_OR:    r_alu_ctl = ALU_OR;
            F_NOR:   r_alu_ctl = ALU_NOR;
            F_SLT:   r_alu_ctl = ALU_SLT;
            default: funct_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:                      state_d = S_MEM_ADDR;
                    OP_RTYPE:                          state_d = funct_legal ? S_R_EXEC : S_TRAP;
                    OP_BEQ, OP_BNE:                    state_d = S_BRANCH;
                    OP_J:                              state_d = S_JUMP;
                    OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_I_EXEC;
                    default:                           state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            S_MEM_WB, S_MEM_WR, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: state_d = S_FETCH;
            default:    state_d = S_TRAP;
        endcase
    end

    // Outputs are forced to their defaults while reset is held, so a reset in MEM_WR writes nothing.
    always_comb begin
        alu_ctl    = ALU_ADD;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        imm_zext   = 1'b0;
        pc_source  = 2'd0;
        pc_en      = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    ir_write  = 1'b1;
                    pc_en     = 1'b1;
                    alu_src_b = 2'd1;
                end
                S_DECODE: alu_src_b = 2'd3;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    iord       = 1'b1;
                    instr_done = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_ctl   = r_alu_ctl;
                end
                S_R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 1'b1;
                    alu_ctl    = ALU_SUB;
                    pc_source  = 2'd1;
                    pc_en      = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    pc_source  = 2'd2;
                    pc_en      = 1'b1;
                    instr_done = 1'b1;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    case (opcode)
                        OP_SLTI: alu_ctl = ALU_SLT;
                        OP_ANDI: begin
                            alu_ctl  = ALU_AND;
                            imm_zext = 1'b1;
                        end
                        OP_ORI: begin
                            alu_ctl  = ALU_OR;
                            imm_zext = 1'b1;
                        end
                        default: alu_ctl = ALU_ADD;
                    endcase
                end
                S_I_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                S_TRAP:  illegal = 1'b1;
                default: illegal = 1'b0;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: a driver walks random instructions through a
// phase-level reference model and queues expected outputs, and a monitor checks every cycle.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       alu_zero;
    logic [3:0] alu_ctl;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       imm_zext;
    logic [1:0] pc_source;
    logic       pc_en, ir_write, mem_read, mem_write, iord;
    logic       reg_write, reg_dst, mem_to_reg, instr_done, illegal;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .alu_zero(alu_zero),
        .alu_ctl(alu_ctl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_zext(imm_zext),
        .pc_source(pc_source), .pc_en(pc_en), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .iord(iord), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .instr_done(instr_done), .illegal(illegal), .state(state)
    );

    typedef enum int {P_FETCH, P_DECODE, P_ADDR, P_MRD, P_MWB, P_MWR, P_REX, P_RWB,
                      P_BR, P_J, P_IEX, P_IWB, P_TRAP} phase_e;
    typedef enum int {C_LW, C_SW, C_R, C_BR, C_J, C_I, C_ILL} class_e;

    typedef struct packed {
        logic [3:0] st;
        logic [3:0] ctl;
        logic       src_a;
        logic [1:0] src_b;
        logic       zext;
        logic [1:0] pc_src;
        logic       pc_en;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       illegal;
    } obs_t;

    typedef struct {
        obs_t   v;
        bit     st_known;
        phase_e ph;
        bit     in_rst;
    } exp_t;

    exp_t   exp_q[$];
    phase_e seq_q[$];
    int     r_ctl[int];
    int     i_ctl[int];
    int     errors = 0;
    int     checks = 0;
    int     cycle_no = 0;
    logic [5:0] legal_f [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};
    logic [5:0] i_ops   [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};

    function automatic class_e classify(logic [5:0] op, logic [5:0] fn);
        if (op == 6'h23) return C_LW;
        if (op == 6'h2B) return C_SW;
        if (op == 6'h00) return r_ctl.exists(int'(fn)) ? C_R : C_ILL;
        if (op == 6'h04 || op == 6'h05) return C_BR;
        if (op == 6'h02) return C_J;
        if (i_ctl.exists(int'(op))) return C_I;
        return C_ILL;
    endfunction

    function automatic void build_seq(class_e c, int trap_hold);
        seq_q.delete();
        seq_q.push_back(P_FETCH);
        seq_q.push_back(P_DECODE);
        case (c)
            C_LW: begin seq_q.push_back(P_ADDR); seq_q.push_back(P_MRD); seq_q.push_back(P_MWB); end
            C_SW: begin seq_q.push_back(P_ADDR); seq_q.push_back(P_MWR); end
            C_R:  begin seq_q.push_back(P_REX); seq_q.push_back(P_RWB); end
            C_BR: seq_q.push_back(P_BR);
            C_J:  seq_q.push_back(P_J);
            C_I:  begin seq_q.push_back(P_IEX); seq_q.push_back(P_IWB); end
            default: for (int k = 0; k < trap_hold; k++) seq_q.push_back(P_TRAP);
        endcase
    endfunction

    function automatic obs_t defaults();
        obs_t e;
        e = '0;
        e.ctl = 4'd2;
        return e;
    endfunction

    function automatic obs_t expect_out(phase_e p, logic [5:0] op, logic [5:0] fn, logic z);
        obs_t e;
        e = defaults();
        case (p)
            P_FETCH:  begin e.st = 4'd0; e.mem_read = 1; e.ir_write = 1; e.pc_en = 1; e.src_b = 2'd1; end
            P_DECODE: begin e.st = 4'd1; e.src_b = 2'd3; end
            P_ADDR:   begin e.st = 4'd2; e.src_a = 1; e.src_b = 2'd2; end
            P_MRD:    begin e.st = 4'd3; e.mem_read = 1; e.iord = 1; end
            P_MWB:    begin e.st = 4'd4; e.reg_write = 1; e.mem_to_reg = 1; e.done = 1; end
            P_MWR:    begin e.st = 4'd5; e.mem_write = 1; e.iord = 1; e.done = 1; end
            P_REX:    begin e.st = 4'd6; e.src_a = 1; e.ctl = 4'(r_ctl[int'(fn)]); end
            P_RWB:    begin e.st = 4'd7; e.reg_write = 1; e.reg_dst = 1; e.done = 1; end
            P_BR: begin
                e.st = 4'd8; e.src_a = 1; e.ctl = 4'd6; e.pc_src = 2'd1; e.done = 1;
                e.pc_en = (op == 6'h04) ? z : !z;
            end
            P_J:      begin e.st = 4'd9; e.pc_src = 2'd2; e.pc_en = 1; e.done = 1; end
            P_IEX: begin
                e.st = 4'd10; e.src_a = 1; e.src_b = 2'd2; e.ctl = 4'(i_ctl[int'(op)]);
                e.zext = (op == 6'h0C || op == 6'h0D);
            end
            P_IWB:    begin e.st = 4'd11; e.reg_write = 1; e.done = 1; end
            default:  begin e.st = 4'd15; e.illegal = 1; end
        endcase
        return e;
    endfunction

    task automatic drive_cycle(bit rst, phase_e p, logic [5:0] op, logic [5:0] fn, logic z);
        exp_t e;
        reset    = rst;
        opcode   = op;
        funct    = fn;
        alu_zero = z;
        e.v        = rst ? defaults() : expect_out(p, op, fn, z);
        e.st_known = !rst;
        e.ph       = p;
        e.in_rst   = rst;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // zmode < 0 randomises alu_zero; abort_at is the phase index where reset cuts in (-1: none).
    task automatic run_instr(logic [5:0] op, logic [5:0] fn, int zmode, int abort_at,
                             int trap_hold, int rst_len);
        class_e c;
        bit     aborted;
        c = classify(op, fn);
        build_seq(c, trap_hold);
        aborted = 1'b0;
        for (int i = 0; i < seq_q.size(); i++) begin
            logic [5:0] op_d;
            logic [5:0] fn_d;
            logic       z;
            if (i == abort_at) begin
                aborted = 1'b1;
                break;
            end
            op_d = (seq_q[i] == P_FETCH) ? 6'($urandom) : op;
            fn_d = (seq_q[i] == P_FETCH) ? 6'($urandom) : fn;
            z    = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            drive_cycle(1'b0, seq_q[i], op_d, fn_d, z);
        end
        if (aborted || c == C_ILL) begin
            for (int r = 0; r < ((rst_len < 1) ? 1 : rst_len); r++)
                drive_cycle(1'b1, P_FETCH, 6'($urandom), 6'($urandom), 1'($urandom));
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cycle_no++;
            if (exp_q.size() > 0) begin
                exp_t e;
                obs_t act;
                obs_t want;
                e = exp_q.pop_front();
                act = {state, alu_ctl, alu_src_a, alu_src_b, imm_zext, pc_source, pc_en, ir_write,
                       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, instr_done, illegal};
                want = e.v;
                if (!e.st_known) begin
                    act.st  = 4'd0;
                    want.st = 4'd0;
                end
                checks++;
                if (act !== want) begin
                    errors++;
                    $display("FAIL cyc%0d %s rst=%0b: got st=%0d ctl=%0d bits=%h, want st=%0d ctl=%0d bits=%h",
                             cycle_no, e.ph.name(), e.in_rst, act.st, act.ctl, act, want.st, want.ctl, want);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    initial begin : driver
        r_ctl[32'h20] = 2; r_ctl[32'h22] = 6;  r_ctl[32'h24] = 0;
        r_ctl[32'h25] = 1; r_ctl[32'h27] = 12; r_ctl[32'h2A] = 7;
        i_ctl[32'h08] = 2; i_ctl[32'h0A] = 7;  i_ctl[32'h0C] = 0; i_ctl[32'h0D] = 1;

        reset = 1'b1; opcode = '0; funct = '0; alu_zero = 1'b0;
        @(posedge clk);
        #1;
        for (int r = 0; r < 3; r++) drive_cycle(1'b1, P_FETCH, 6'h00, 6'h20, 1'b0);

        // Directed cases first: reset mid-R_EXEC, each ALU mapping, branch polarity, traps.
        run_instr(6'h00, 6'h20, -1, 2, 0, 3);
        run_instr(6'h23, 6'h00, -1, -1, 0, 0);
        run_instr(6'h2B, 6'h00, -1, -1, 0, 0);
        run_instr(6'h00, 6'h27, -1, -1, 0, 0);
        run_instr(6'h00, 6'h22, -1, -1, 0, 0);
        run_instr(6'h00, 6'h2A, -1, -1, 0, 0);
        run_instr(6'h00, 6'h24, -1, -1, 0, 0);
        run_instr(6'h00, 6'h25, -1, -1, 0, 0);
        run_instr(6'h05, 6'h00, 1, -1, 0, 0);
        run_instr(6'h04, 6'h00, 1, -1, 0, 0);
        run_instr(6'h05, 6'h00, 0, -1, 0, 0);
        run_instr(6'h04, 6'h00, 0, -1, 0, 0);
        run_instr(6'h0D, 6'h00, -1, -1, 0, 0);
        run_instr(6'h0A, 6'h00, -1, -1, 0, 0);
        run_instr(6'h08, 6'h00, -1, -1, 0, 0);
        run_instr(6'h0C, 6'h00, -1, -1, 0, 0);
        run_instr(6'h02, 6'h00, -1, -1, 0, 0);
        run_instr(6'h3F, 6'h00, -1, -1, 10, 1);
        run_instr(6'h00, 6'h01, -1, -1, 3, 2);
        run_instr(6'h2B, 6'h00, -1, 3, 0, 1);
        run_instr(6'h23, 6'h00, -1, 4, 0, 1);

        for (int n = 0; n < 250; n++) begin
            logic [5:0] op;
            logic [5:0] fn;
            int         abort_at;
            fn = 6'($urandom);
            case ($urandom_range(0, 9))
                0:       op = 6'h23;
                1:       op = 6'h2B;
                2, 9:    begin op = 6'h00; fn = legal_f[$urandom_range(0, 5)]; end
                3:       op = 6'h04;
                4:       op = 6'h05;
                5:       op = 6'h02;
                6:       op = i_ops[$urandom_range(0, 3)];
                7:       op = 6'h00;
                default: op = 6'($urandom);
            endcase
            abort_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
            run_instr(op, fn, -1, abort_at, int'($urandom_range(0, 4)), int'($urandom_range(1, 3)));
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
